// File: rtl/fp_mem_wb_pipe.sv
// FP MEM->WB pipeline register: head entry plus one skid entry behind a registered
// ready, with pre-muxed forwarding of the entry about to retire.
module fp_mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_dm_out,
  input  logic [DATA_W-1:0] in_mov_out,
  input  logic [DATA_W-1:0] in_norm_out,
  input  logic [1:0]        in_wb_sel,
  input  logic              in_wb_fp_en,
  input  logic              in_wb_int_en,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dm_out,
  output logic [DATA_W-1:0] mov_out,
  output logic [DATA_W-1:0] norm_out,
  output logic [1:0]        wb_sel,
  output logic              wb_fp_en,
  output logic              wb_int_en,
  output logic [RD_W-1:0]   rd,
  output logic              fwd_fp_valid,
  output logic              fwd_int_valid,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [DATA_W-1:0] dm;
    logic [DATA_W-1:0] mov;
    logic [DATA_W-1:0] norm;
    logic [1:0]        sel;
    logic              fp_en;
    logic              int_en;
    logic [RD_W-1:0]   rd;
  } entry_t;

  function automatic logic [DATA_W-1:0] fwd_mux(input entry_t e);
    logic [DATA_W-1:0] r;
    case (e.sel)
      2'b00:   r = e.dm;
      2'b01:   r = e.mov;
      2'b10:   r = e.norm;
      default: r = '0;
    endcase
    return r;
  endfunction

  entry_t in_ent;
  entry_t hd_p1, sk_p1;
  entry_t hd_nxt, sk_nxt;
  logic   hd_vld_p1, sk_vld_p1;
  logic   hd_vld_nxt, sk_vld_nxt;
  logic   in_ready_q;
  logic   acc, drn;

  assign in_ent = {in_dm_out, in_mov_out, in_norm_out, in_wb_sel,
                   in_wb_fp_en, in_wb_int_en, in_rd};
  assign acc    = in_valid & in_ready_q;
  assign drn    = hd_vld_p1 & out_ready;

  always_comb begin
    hd_nxt     = hd_p1;
    sk_nxt     = sk_p1;
    hd_vld_nxt = hd_vld_p1;
    sk_vld_nxt = sk_vld_p1;
    if (flush) begin
      hd_vld_nxt = 1'b0;
      sk_vld_nxt = 1'b0;
    end else if (!hd_vld_p1 || drn) begin
      if (sk_vld_p1) begin
        hd_nxt     = sk_p1;
        hd_vld_nxt = 1'b1;
        sk_vld_nxt = 1'b0;
        if (acc) begin
          sk_nxt     = in_ent;
          sk_vld_nxt = 1'b1;
        end
      end else if (acc) begin
        hd_nxt     = in_ent;
        hd_vld_nxt = 1'b1;
      end else begin
        hd_vld_nxt = 1'b0;
      end
    end else if (acc) begin
      // Head stalled: the registered ready guarantees the skid slot is free here.
      sk_nxt     = in_ent;
      sk_vld_nxt = 1'b1;
    end
  end

  // Stage p1: head/skid storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_p1      <= '0;
      sk_p1      <= '0;
      hd_vld_p1  <= 1'b0;
      sk_vld_p1  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      hd_p1      <= hd_nxt;
      sk_p1      <= sk_nxt;
      hd_vld_p1  <= hd_vld_nxt;
      sk_vld_p1  <= sk_vld_nxt;
      in_ready_q <= ~sk_vld_nxt;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = hd_vld_p1;
  assign dm_out        = hd_p1.dm;
  assign mov_out       = hd_p1.mov;
  assign norm_out      = hd_p1.norm;
  assign wb_sel        = hd_p1.sel;
  assign rd            = hd_p1.rd;
  assign wb_fp_en      = hd_vld_p1 & hd_p1.fp_en;
  assign wb_int_en     = hd_vld_p1 & hd_p1.int_en;
  assign fwd_fp_valid  = wb_fp_en;
  assign fwd_int_valid = wb_int_en;
  assign fwd_data      = fwd_mux(hd_p1);
  assign occupancy     = {1'b0, hd_vld_p1} + {1'b0, sk_vld_p1};

endmodule
